// File: rtl/execute_mc.sv
// LEGv8 execute stage: ALU, branch target and EX/MEM-over-MEM/WB forwarding,
// plus an iterative shift-add multiplier that stalls upstream while it runs.
module execute_mc #(
    parameter int N = 64,
    parameter int R = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_E,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic         MulOp,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    input  logic [4:0]   ID_EX_rn,
    input  logic [4:0]   ID_EX_rm,
    input  logic [4:0]   EX_MEM_rd,
    input  logic [4:0]   MEM_WB_rd,
    input  logic         EX_MEM_regWrite,
    input  logic         MEM_WB_regWrite,
    input  logic [N-1:0] EX_MEM_aluResult,
    input  logic [N-1:0] MEM_WB_result,
    output logic [N-1:0] PCBranch_E,
    output logic [N-1:0] aluResult_E,
    output logic [N-1:0] writeData_E,
    output logic         zero_E,
    output logic         stall_E,
    output logic         mul_busy
);

    localparam int K  = N / R;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;

    logic [N-1:0]   src_a, src_b, alu_b, alu_y, pp;
    logic           issue, done_out;

    // EX/MEM is checked first so the younger result always wins.
    always_comb begin
        src_a = readData1_E;
        if (EX_MEM_regWrite && EX_MEM_rd == ID_EX_rn && EX_MEM_rd != 5'd31)
            src_a = EX_MEM_aluResult;
        else if (MEM_WB_regWrite && MEM_WB_rd == ID_EX_rn && MEM_WB_rd != 5'd31)
            src_a = MEM_WB_result;

        src_b = readData2_E;
        if (EX_MEM_regWrite && EX_MEM_rd == ID_EX_rm && EX_MEM_rd != 5'd31)
            src_b = EX_MEM_aluResult;
        else if (MEM_WB_regWrite && MEM_WB_rd == ID_EX_rm && MEM_WB_rd != 5'd31)
            src_b = MEM_WB_result;
    end

    always_comb begin
        alu_b = AluSrc ? signImm_E : src_b;
        case (AluControl)
            4'b0000: alu_y = src_a & alu_b;
            4'b0001: alu_y = src_a | alu_b;
            4'b0010: alu_y = src_a + alu_b;
            4'b0110: alu_y = src_a - alu_b;
            4'b0111: alu_y = alu_b;
            default: alu_y = '0;
        endcase
    end

    // Partial products for the low R multiplier bits; operands shift each cycle.
    always_comb begin
        pp = '0;
        for (int j = 0; j < R; j++)
            if (mplier_q[j]) pp = pp + (mcand_q << j);
    end

    assign issue = valid_E && MulOp && !flush_E;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: if (issue) begin
                mcand_d  = src_a;
                mplier_d = src_b;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: if (flush_E) begin
                state_d = IDLE;
            end else begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << R;
                mplier_d = mplier_q >> R;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Stall is gated by reset so it falls the instant reset asserts.
    assign stall_E     = reset && !flush_E &&
                         ((state_q == IDLE && issue) || state_q == RUN);
    assign done_out    = (state_q == DONE) && !flush_E;
    assign aluResult_E = done_out ? acc_q : alu_y;
    assign zero_E      = (aluResult_E == '0);
    assign mul_busy    = (state_q != IDLE);
    assign PCBranch_E  = PC_E + (signImm_E << 2);
    assign writeData_E = src_b;

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
Parametrised successor to the single-cycle execute stage of the pipelined LEGv8 core. It keeps the ALU/branch-target datapath and EX/MEM-over-MEM/WB forwarding. It adds a multi-cycle iterative multiplier (MUL) with a configurable number of bits retired per cycle, a pipeline stall output, and a flush input. It sits between the ID/EX and EX/MEM pipeline registers. The hazard unit ORs stall_E into its freeze of PC, IF/ID and ID/EX.

Parameters:
N, 64, datapath width in bits
R, 1, multiplier bits retired per cycle; N mod R must be 0; iteration count K = N/R

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (reset asserted while 0)
valid_E  in  1  ID/EX holds a real instruction (not a bubble)
flush_E  in  1  abort the instruction in EX
AluSrc  in  1  ALU B source: 0 = register, 1 = signImm_E
AluControl  in  4  ALU op (0000 and, 0001 or, 0010 add, 0110 sub, 0111 pass B)
MulOp  in  1  the instruction in EX is MUL (overrides AluControl)
PC_E, signImm_E, readData1_E, readData2_E  in  N  ID/EX operands
ID_EX_rn, ID_EX_rm, EX_MEM_rd, MEM_WB_rd  in  5  register numbers
EX_MEM_regWrite, MEM_WB_regWrite  in  1  write enables of the later stages
EX_MEM_aluResult, MEM_WB_result  in  N  forwarding data
PCBranch_E  out  N  PC_E + (signImm_E << 2)
aluResult_E  out  N  ALU result, or product low N bits on the MUL completion cycle
writeData_E  out  N  forwarded rm value, used for stores
zero_E  out  1  aluResult_E == 0
stall_E  out  1  hold the upstream stages
mul_busy  out  1  FSM not IDLE

Behaviour:
- Forwarding per source S in {rn, rm}:
  - fwd = EX/MEM when EX_MEM_regWrite and EX_MEM_rd == S and EX_MEM_rd != 31.
  - Otherwise fwd = MEM/WB under the same rule using MEM_WB_rd.
  - Otherwise the register file value is used.
  - EX/MEM always wins over MEM/WB.
- ALU B = signImm_E when AluSrc = 1; the immediate is never replaced by forwarded data.
- writeData_E = forwarded rm value regardless of AluSrc.
- Non-MUL instructions are combinational, zero latency, and stall_E = 0.
- MUL FSM states: IDLE, RUN, DONE.
  - IDLE: if valid_E & MulOp & !flush_E, stall_E = 1 combinationally in the same cycle. On the clock edge, latch the forwarded rn/rm into multiplicand/multiplier registers, clear the accumulator, set the counter to 0, go to RUN.
  - RUN: stall_E = 1. Each cycle adds the partial products of the next R multiplier bits (shift-add, unsigned; the low N bits equal the two's-complement product). The counter increments each cycle. When the counter == K-1, go to DONE.
  - DONE: stall_E = 0. aluResult_E = accumulator[N-1:0] and zero_E reflects it. Go to IDLE unconditionally. A MulOp still visible in this cycle does not restart the FSM.
- Latency: stall_E is high for exactly K+1 cycles (issue + K RUN cycles). The result is valid in the following DONE cycle.
- Operands are latched at issue, so forwarding-source changes during the stall do not affect the product.
- flush_E in RUN or DONE: go to IDLE at the next edge. stall_E drops in the flush cycle itself. No result is produced.
- reset low at any time: state IDLE, counter 0, accumulator and operand registers 0, stall_E = 0, mul_busy = 0, all immediately (asynchronous).
- Outputs outside DONE for MUL: aluResult_E shows the ALU path; the downstream stage ignores it because stall_E is high.
- PCBranch_E and writeData_E are always combinational and unaffected by the FSM.

Test Plan:
1. ADD with rn=3, EX_MEM_rd=3, EX_MEM_regWrite=1, EX_MEM_aluResult=100, readData2=7, AluSrc=0 -> aluResult_E=107, zero_E=0, stall_E=0.
2. rn=3 also matches MEM_WB_rd with value 200 -> result still uses 100. With rn=rd=31 and regWrite=1 -> no forward, readData1 used.
3. AluSrc=1, signImm=8, rm matches EX/MEM with value 55, pass-B op -> aluResult_E=8, writeData_E=55. PC_E=0x100, signImm=8 -> PCBranch_E=0x120.
4. MUL 6 x 7 with N=64, R=1 -> stall_E high for 65 cycles, then the DONE cycle gives aluResult_E=42 and zero_E=0. With R=4 -> stall for 17 cycles.
5. MUL (-3) x 5 -> 0xFFFF_FFFF_FFFF_FFF1. MUL 0 x 12345 -> 0 with zero_E=1. Back-to-back MULs each take K+1 stall cycles plus a DONE cycle.
6. flush_E on the 10th RUN cycle -> stall_E=0 in that cycle, FSM IDLE next cycle. reset driven low mid-RUN -> stall_E and mul_busy drop to 0 immediately, and a following MUL completes correctly.
